dma_bank_sequencer: RTL and testbench

DMA_BANK_SEQUENCER -- requirements
Module: dma_bank_sequencer

---
 rtl/dma_bank_sequencer.sv | 148 ++++++++++++++
 tb/tb_dma_bank_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dma_bank_sequencer.sv
// DMA burst sequencer: streams cmd_len words between a write/read stream and four crossbar banks.
// It yields to PE traffic for up to MAX_WAIT cycles per word, then stalls the PE. Reads return through a 2-entry credit FIFO.
module dma_bank_sequencer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int NB       = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W+1:0] cmd_addr,
    input  logic [ADDR_W+2:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    input  logic [NB-1:0]     pe_read_en,
    input  logic [NB-1:0]     pe_write_en,
    output logic [NB-1:0]     pe_stall,
    output logic              dma_write_en,
    output logic              dma_read_en,
    output logic [1:0]        dma_bank_sel,
    output logic [ADDR_W-1:0] dma_local_addr,
    output logic [DATA_W-1:0] dma_data_in,
    input  logic [DATA_W-1:0] dma_data_out
);
    localparam int AW = ADDR_W + 2;
    localparam int LW = ADDR_W + 3;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [AW-1:0]     cur_addr_q, cur_addr_d;
    logic [LW-1:0]     remaining_q, remaining_d;
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              in_flight_q, in_flight_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0]        count_q, count_d;

    logic [1:0] bank;
    logic       conflict, credit, issue, pop;

    always_comb begin
        bank     = cur_addr_q[AW-1:ADDR_W];
        conflict = pe_read_en[bank] | pe_write_en[bank];
        // A read holds a credit from issue until it is popped, so the FIFO can never overflow.
        credit   = ({1'b0, count_q} + {2'b00, in_flight_q}) < 3'd2;
        issue    = (state_q == RUN) && (!conflict || wait_cnt_q == WW'(MAX_WAIT))
                   && (write_q ? wr_valid : credit);
        pop      = (count_q != 2'd0) && rd_ready;
    end

    assign cmd_ready      = (state_q == IDLE) && !rst;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign wr_ready       = issue && write_q;
    assign dma_write_en   = issue && write_q;
    assign dma_read_en    = issue && !write_q;
    assign dma_bank_sel   = issue ? bank : 2'b00;
    assign dma_local_addr = issue ? cur_addr_q[ADDR_W-1:0] : '0;
    assign dma_data_in    = (issue && write_q) ? wr_data : '0;
    assign pe_stall       = (issue && conflict) ? (NB'(1) << bank) : '0;
    assign rd_valid       = (count_q != 2'd0);
    assign rd_data        = rd_valid ? fifo_q[rptr_q] : '0;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        in_flight_d = issue && !write_q;
        fifo_d      = fifo_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d     = cmd_write;
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_len;
                    wait_cnt_d  = '0;
                    state_d     = (cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    cur_addr_d  = cur_addr_q + AW'(1);
                    remaining_d = remaining_q - LW'(1);
                    wait_cnt_d  = '0;
                    if (remaining_q == LW'(1)) state_d = write_q ? DONE : DRAIN;
                end else if (conflict && wait_cnt_q != WW'(MAX_WAIT)) begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            DRAIN: begin
                if (count_q == 2'd0 && !in_flight_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Crossbar read data is valid the cycle after the enable.
        if (in_flight_q) begin
            fifo_d[wptr_q] = dma_data_out;
            wptr_d         = !wptr_q;
        end
        if (pop) rptr_d = !rptr_q;
        count_d = count_q + {1'b0, in_flight_q} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            in_flight_q <= 1'b0;
            fifo_q      <= '{default: '0};
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            in_flight_q <= in_flight_d;
            fifo_q      <= fifo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_dma_bank_sequencer.sv
// Bench for dma_bank_sequencer: directed bursts plus randomized traffic against a transaction-level model.
module tb_dma_bank_sequencer;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [12:0] cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        busy, done;
    logic [3:0]  pe_read_en, pe_write_en, pe_stall;
    logic        dma_write_en, dma_read_en;
    logic [1:0]  dma_bank_sel;
    logic [9:0]  dma_local_addr;
    logic [31:0] dma_data_in, dma_data_out;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] exp_q [$];

    dma_bank_sequencer #(.DATA_W(32), .ADDR_W(10), .NB(4), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done),
        .pe_read_en(pe_read_en), .pe_write_en(pe_write_en), .pe_stall(pe_stall),
        .dma_write_en(dma_write_en), .dma_read_en(dma_read_en),
        .dma_bank_sel(dma_bank_sel), .dma_local_addr(dma_local_addr),
        .dma_data_in(dma_data_in), .dma_data_out(dma_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return int'($urandom_range(99, 0)) < p;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0; rd_ready = 0;
        pe_read_en = '0; pe_write_en = '0; dma_data_out = '0;
    endtask

    // One burst end to end; the model tracks words issued/popped, the address sequence and PE wait rules.
    task automatic run_cmd(input bit wr, input logic [11:0] addr, input int len, input int pe_pct,
                           input logic [3:0] pe_fix, input int wv_pct, input int rr_pct, input int rr_hold);
        int issued, popped, waited;
        bit prev_rd, exp_done, done_seen, exp_issue, conflict;
        logic [11:0] ea;
        int occ;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = 13'(len);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        cmd_valid = 0;
        issued = 0; popped = 0; waited = 0; prev_rd = 0; done_seen = 0;
        exp_done = (len == 0);
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                pe_read_en[i]  = pct(pe_pct);
                pe_write_en[i] = pct(pe_pct) | pe_fix[i];
            end
            wr_valid     = pct(wv_pct);
            wr_data      = $urandom;
            rd_ready     = (cyc >= rr_hold) && pct(rr_pct);
            dma_data_out = $urandom;
            @(negedge clk);
            ea        = addr + 12'(issued);
            conflict  = pe_read_en[ea[11:10]] | pe_write_en[ea[11:10]];
            exp_issue = (issued < len) && (!conflict || waited >= MAX_WAIT)
                        && (wr ? wr_valid : (issued - popped) < 2);
            chk("issue", dma_write_en | dma_read_en, exp_issue);
            chk("en_exclusive", dma_write_en & dma_read_en, 0);
            chk("wr_ready", wr_ready, exp_issue && wr);
            chk("pe_stall", pe_stall, (exp_issue && conflict) ? (4'b0001 << ea[11:10]) : 4'b0000);
            if (exp_issue) begin
                chk("dir", dma_write_en, wr);
                chk("bank", dma_bank_sel, ea[11:10]);
                chk("local", dma_local_addr, ea[9:0]);
                if (wr) chk("wdata", dma_data_in, wr_data);
            end
            occ = exp_q.size();
            chk("rd_valid", rd_valid, occ > 0);
            if (rd_valid && rd_ready) begin
                chk("rd_nonempty", occ > 0, 1);
                if (occ > 0) begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                    popped++;
                end
            end
            if (prev_rd) exp_q.push_back(dma_data_out);
            if (wr || len == 0) chk("done", done, exp_done);
            else if (done) chk("done_after_drain", popped == len && !prev_rd && exp_q.size() == 0, 1);
            chk("busy", busy, 1);
            if (exp_issue) begin
                issued++;
                waited = 0;
            end else if (conflict && issued < len) begin
                waited++;
            end
            exp_done = exp_issue && wr && issued == len;
            prev_rd  = exp_issue && !wr;
            done_seen = done;
            @(posedge clk); #1;
            if (done_seen) break;
        end
        idle_inputs();
        chk("done_seen", done_seen, 1);
        chk("issued_total", issued, len);
        if (!wr) chk("popped_total", popped, len);
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        chk("cmd_ready_after", cmd_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        idle_inputs();
        rst = 1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dma_en", {dma_write_en, dma_read_en}, 0);
        chk("rst_rd_valid", rd_valid, 0);
        repeat (3) @(posedge clk);
        #1; rst = 0;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        run_cmd(1, 12'h3FE, 4, 0, 4'b0000, 100, 100, 0);   // bank0 -> bank1 crossing
        run_cmd(0, 12'hFFF, 2, 0, 4'b0000, 100, 100, 0);   // bank3 -> bank0 wrap
        run_cmd(1, 12'h800, 2, 0, 4'b0100, 100, 100, 0);   // held PE conflict on bank2
        run_cmd(0, 12'h123, 6, 0, 4'b0000, 100, 100, 20);  // read credit stall
        run_cmd(1, 12'h055, 0, 0, 4'b0000, 100, 100, 0);   // empty burst
        run_cmd(0, 12'h400, 0, 0, 4'b0000, 100, 100, 0);

        // Reset while the 3rd word of a 10-word write issues.
        cmd_valid = 1; cmd_write = 1; cmd_addr = 12'h200; cmd_len = 13'd10;
        @(posedge clk); #1;
        cmd_valid = 0; wr_valid = 1;
        n = 0;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            wr_data = $urandom;
            @(negedge clk);
            if (dma_write_en) n++;
            if (n < 3) begin
                @(posedge clk); #1;
            end
        end
        chk("third_issue_seen", n, 3);
        rst = 1;
        #1;
        chk("mid_rst_dma_en", {dma_write_en, dma_read_en}, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", {dma_bank_sel, dma_local_addr, dma_data_in}, 0);
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_cmd_ready", cmd_ready, 1);
            @(posedge clk); #1;
        end
        run_cmd(1, 12'h200, 3, 0, 4'b0000, 100, 100, 0);

        for (int k = 0; k < 14; k++) begin
            run_cmd(bit'($urandom_range(1, 0)), 12'($urandom), int'($urandom_range(12, 0)),
                    15, 4'b0000, 70, 60, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
